// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32 datapath constants, register indices and regfile state type
package rv_pkg;
   localparam int XLEN         = 32;
   localparam int NREG_DEFAULT = 32;

   localparam int REG_ZERO = 0;
   localparam int REG_RA   = 1;
   localparam int REG_SP   = 2;
   localparam int REG_FP   = 8;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } rf_state_t;
endpackage

// File: rtl/regfile_bank_if.sv
// rtl/regfile_bank_if.sv - read/write/issue bus between datapath stages and the register file
interface regfile_bank_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5,
   parameter int NRD  = 2
);
   logic                 rdy;
   logic [NRD*AW-1:0]    rs_addr;
   logic [NRD*XLEN-1:0]  rs_data;
   logic [NRD-1:0]       rs_busy;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [XLEN-1:0]      wr_data;
   logic                 iss_en;
   logic [AW-1:0]        iss_rd;

   modport master (
      input  rdy, rs_data, rs_busy,
      output rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd
   );

   modport slave (
      output rdy, rs_data, rs_busy,
      input  rs_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-writeback bits with per-port lookup
module regfile_scoreboard #(
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int AW   = $clog2(NREG)
) (
   input  logic              CLK,
   input  logic              RST_X,
   input  logic              i_run,
   input  logic              i_set_en,
   input  logic [AW-1:0]     i_set_addr,
   input  logic              i_clr_en,
   input  logic [AW-1:0]     i_clr_addr,
   input  logic [NRD*AW-1:0] i_rd_addr,
   output logic [NRD-1:0]    o_busy
);
   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_set_mask;
   logic [NREG-1:0] w_clr_mask;

   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (i_run && i_set_en && (i_set_addr != '0))
         w_set_mask = NREG'(1) << i_set_addr;
      if (i_run && i_clr_en && (i_clr_addr != '0))
         w_clr_mask = NREG'(1) << i_clr_addr;
   end

   // Set is applied after clear so a same-edge re-issue keeps the register pending.
   always_ff @(posedge CLK or posedge RST_X) begin
      if (RST_X)
         r_busy <= '0;
      else
         r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
   end

   always_comb begin
      logic [AW-1:0] w_a;
      o_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         w_a = i_rd_addr[i*AW +: AW];
         o_busy[i] = r_busy[w_a] &
                     ~(i_run && i_clr_en && (i_clr_addr == w_a) && (w_a != '0));
      end
   end
endmodule

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - RV32 integer register file with init sweep, write bypass and busy scoreboard
module regfile_bank
   import rv_pkg::*;
#(
   parameter int               XLEN    = rv_pkg::XLEN,
   parameter int               NREG    = NREG_DEFAULT,
   parameter int               NRD     = 2,
   parameter logic [XLEN-1:0]  SP_INIT = 32'h0000ff00,
   parameter logic [XLEN-1:0]  FP_INIT = 32'h0000ff00
) (
   input  logic         CLK,
   input  logic         RST_X,
   regfile_bank_if.slave bus
);
   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0]     r_mem [NREG];
   rf_state_t           r_state;
   rf_state_t           w_state_nxt;
   logic [AW-1:0]       r_ptr;
   logic                w_run;
   logic                w_wr_ok;
   logic [XLEN-1:0]     w_init_val;
   logic [NRD*XLEN-1:0] w_rs_data;
   logic [NRD-1:0]      w_busy;

   always_ff @(posedge CLK or posedge RST_X) begin
      if (RST_X)
         r_state <= INIT;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if ((r_state == INIT) && (r_ptr == AW'(NREG-1)))
         w_state_nxt = RUN;
   end

   always_comb begin
      w_run = (r_state == RUN) && !RST_X;
   end

   assign bus.rdy = w_run;

   always_ff @(posedge CLK or posedge RST_X) begin
      if (RST_X)
         r_ptr <= '0;
      else if (r_state == INIT)
         r_ptr <= r_ptr + AW'(1);
   end

   assign w_init_val = (r_ptr == AW'(REG_SP)) ? SP_INIT :
                       (r_ptr == AW'(REG_FP)) ? FP_INIT : '0;
   assign w_wr_ok    = w_run && bus.wr_en && (bus.wr_addr != AW'(REG_ZERO));

   // Storage has no reset; the sweep after every reset rewrites each entry.
   always_ff @(posedge CLK) begin
      if (r_state == INIT)
         r_mem[r_ptr] <= w_init_val;
      else if (w_wr_ok)
         r_mem[bus.wr_addr] <= bus.wr_data;
   end

   always_comb begin
      logic [AW-1:0] w_a;
      w_rs_data = '0;
      for (int i = 0; i < NRD; i++) begin
         w_a = bus.rs_addr[i*AW +: AW];
         if (!w_run || (w_a == AW'(REG_ZERO)))
            w_rs_data[i*XLEN +: XLEN] = '0;
         else if (w_wr_ok && (bus.wr_addr == w_a))
            w_rs_data[i*XLEN +: XLEN] = bus.wr_data;
         else
            w_rs_data[i*XLEN +: XLEN] = r_mem[w_a];
      end
   end

   assign bus.rs_data = w_rs_data;
   assign bus.rs_busy = w_busy & {NRD{w_run}};

   regfile_scoreboard #(
      .NREG (NREG),
      .NRD  (NRD),
      .AW   (AW)
   ) u_scoreboard (
      .CLK        (CLK),
      .RST_X      (RST_X),
      .i_run      (w_run),
      .i_set_en   (bus.iss_en),
      .i_set_addr (bus.iss_rd),
      .i_clr_en   (bus.wr_en),
      .i_clr_addr (bus.wr_addr),
      .i_rd_addr  (bus.rs_addr),
      .o_busy     (w_busy)
   );
endmodule
